// File: rtl/reg_serializer.sv
// reg_serializer: 16-bit parallel-to-serial shifter, MSB first, with a
// one-word holding buffer so back-to-back words stream with no gap cycle.
//
// Offer handshake: a word on `in` is taken on a rising edge where load=1 and
// ready=1. ready is 1 exactly while the holding buffer is empty. When ready=0,
// load is ignored and the offered word is dropped. The offerer is expected to
// keep load/in stable until it sees the edge on which ready was 1.
module reg_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sframe,
    output logic             busy,
    output logic             done,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sframe_q, sframe_d;
    logic             done_q, done_d;
    logic             accept;
    logic             last_edge;

    assign accept    = load & ~hold_valid_q;
    assign last_edge = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // Next-state logic: start, shift, hand off from buffer or input, or stop.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_edge) begin
                    if (hold_valid_q) begin
                        // Buffer full means ready=0, so load is ignored here.
                        shreg_d      = hold_q;
                        cnt_d        = '0;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = in;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d       = in;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
        // Serial outputs are computed from next state so they can be registered.
        sframe_d = (state_d == SHIFT);
        sout_d   = sframe_d & shreg_d[WIDTH-1];
        done_d   = sframe_d & (cnt_d == LAST_BIT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sout_q       <= 1'b0;
            sframe_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sout_q       <= sout_d;
            sframe_q     <= sframe_d;
            done_q       <= done_d;
        end
    end

    assign ready     = ~hold_valid_q;
    assign sout      = sout_q;
    assign sframe    = sframe_q;
    assign done      = done_q;
    assign busy      = sframe_q | hold_valid_q;
    assign dbg_state = (state_q == SHIFT);

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: scenario tasks push expected bits into a queue,
// a negedge monitor pops and compares the serial stream.
module tb_reg_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in_w = 16'h0000;
    logic        ready, sout, sframe, busy, done, dbg_state;

    int tests_run = 0;
    int fails = 0;
    int done_count = 0;
    bit mon_en = 1'b0;

    // Each entry is {done_expected, sout_expected}.
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    reg_serializer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_w), .load(load),
        .ready(ready), .sout(sout), .sframe(sframe), .busy(busy),
        .done(done), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--)
            exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, w[i]});
    endtask

    // Monitor: compares serial output against the scoreboard every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_count++;
            tests_run++;
            if (busy !== (sframe | ~ready)) begin
                fails++;
                $display("FAIL busy_rule: busy=%b sframe=%b ready=%b", busy, sframe, ready);
            end
            if (sframe === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_bit: sframe=1 sout=%b, required no frame", sout);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({done, sout} !== mon_e) begin
                        fails++;
                        $display("FAIL bit_stream: done/sout=%b%b required %b%b",
                                 done, sout, mon_e[1], mon_e[0]);
                    end
                end
            end else begin
                tests_run++;
                if (sout !== 1'b0 || done !== 1'b0 || sframe !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_outputs: sframe=%b sout=%b done=%b required 0 0 0",
                             sframe, sout, done);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        in_w  = 16'hFFFF;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({sout, sframe, done, busy, ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_state: sout/sframe/done/busy/ready=%b required 00001",
                     {sout, sframe, done, busy, ready});
        end
        load   = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if ({sout, sframe, done, busy, ready, dbg_state} !== 6'b000010) begin
                fails++;
                $display("FAIL idle_stable: cycle %0d outputs=%b required 000010", i,
                         {sout, sframe, done, busy, ready, dbg_state});
            end
        end
    endtask

    task automatic test_single();
        int d0;
        d0 = done_count;
        load = 1'b1;
        in_w = 16'hA5C3;
        push_word(16'hA5C3);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            load = 1'b0;
            tests_run++;
            if (sframe !== (i < 16)) begin
                fails++;
                $display("FAIL single_frame: cycle %0d sframe=%b required %b", i, sframe, (i < 16));
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || done_count - d0 != 1) begin
            fails++;
            $display("FAIL single_done: left=%0d dones=%0d required 0 and 1",
                     exp_q.size(), done_count - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_count;
        load = 1'b1;
        in_w = 16'hFFFF;
        push_word(16'hFFFF);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (i == 0) load = 1'b0;
            if (i == 2) begin
                tests_run++;
                if (ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready_before: ready=%b required 1", ready);
                end
                load = 1'b1;
                in_w = 16'h0001;
                push_word(16'h0001);
            end
            if (i == 3 || i == 10) begin
                load = 1'b0;
                tests_run++;
                if (ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_ready_after: cycle %0d ready=%b required 0", i, ready);
                end
            end
            tests_run++;
            if (sframe !== (i < 32)) begin
                fails++;
                $display("FAIL b2b_frame: cycle %0d sframe=%b required %b", i, sframe, (i < 32));
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || done_count - d0 != 2) begin
            fails++;
            $display("FAIL b2b_done: left=%0d dones=%0d required 0 and 2",
                     exp_q.size(), done_count - d0);
        end
    endtask

    task automatic test_overflow();
        int d0;
        d0 = done_count;
        load = 1'b1;
        in_w = 16'h1111;
        push_word(16'h1111);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tests_run++;
                if (ready !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_ready_hold: ready=%b required 1", ready);
                end
                in_w = 16'h2222;
                push_word(16'h2222);
            end
            if (i == 1) begin
                // Keep offering through the handoff edge; none of it may land.
                tests_run++;
                if (ready !== 1'b0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_full: ready=%b busy=%b required 0 1", ready, busy);
                end
                in_w = 16'h1234;
            end
            if (i == 16) begin
                load = 1'b0;
                tests_run++;
                if (ready !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_ready_release: ready=%b required 1", ready);
                end
            end
            tests_run++;
            if (sframe !== (i < 32)) begin
                fails++;
                $display("FAIL ovf_frame: cycle %0d sframe=%b required %b", i, sframe, (i < 32));
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || done_count - d0 != 2) begin
            fails++;
            $display("FAIL ovf_done: left=%0d dones=%0d required 0 and 2",
                     exp_q.size(), done_count - d0);
        end
    endtask

    task automatic test_handoff();
        int d0;
        d0 = done_count;
        load = 1'b1;
        in_w = 16'h5A5A;
        push_word(16'h5A5A);
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || ready !== 1'b1) begin
            fails++;
            $display("FAIL handoff_wait: done=%b ready=%b required 1 1", done, ready);
        end
        load = 1'b1;
        in_w = 16'h8000;
        push_word(16'h8000);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            load = 1'b0;
            tests_run++;
            if (sframe !== (i < 16)) begin
                fails++;
                $display("FAIL handoff_frame: cycle %0d sframe=%b required %b", i, sframe, (i < 16));
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || done_count - d0 != 2) begin
            fails++;
            $display("FAIL handoff_done: left=%0d dones=%0d required 0 and 2",
                     exp_q.size(), done_count - d0);
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        d0 = done_count;
        load = 1'b1;
        in_w = 16'hF0F0;
        push_word(16'hF0F0);
        // Nine edges in: the cycle presenting bit 7.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            load = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({sout, sframe, done, busy, ready} !== 5'b00001) begin
            fails++;
            $display("FAIL midreset_state: sout/sframe/done/busy/ready=%b required 00001",
                     {sout, sframe, done, busy, ready});
        end
        exp_q.delete();
        rst_n = 1'b1;
        tests_run++;
        if (done_count != d0) begin
            fails++;
            $display("FAIL midreset_nodone: dones=%0d required 0", done_count - d0);
        end
        @(negedge clk);
        load = 1'b1;
        in_w = 16'h0F0F;
        push_word(16'h0F0F);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            load = 1'b0;
        end
        tests_run++;
        if (exp_q.size() != 0 || done_count - d0 != 1) begin
            fails++;
            $display("FAIL midreset_after: left=%0d dones=%0d required 0 and 1",
                     exp_q.size(), done_count - d0);
        end
    endtask

    task automatic test_sustained();
        logic [15:0] words[5];
        int nxt, m_cnt, frames, d0;
        bit m_hold, acc;
        for (int k = 0; k < 5; k++) words[k] = 16'($urandom_range(0, 65535));
        nxt = 0; m_cnt = -1; m_hold = 1'b0; frames = 0; d0 = done_count;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (ready !== !m_hold || sframe !== (m_cnt >= 0)) begin
                fails++;
                $display("FAIL sustained_model: cycle %0d ready=%b sframe=%b required %b %b",
                         cyc, ready, sframe, !m_hold, (m_cnt >= 0));
            end
            if (sframe === 1'b1) frames++;
            load = (nxt < 5);
            if (nxt < 5) in_w = words[nxt];
            acc = load && !m_hold;
            if (acc) begin
                push_word(in_w);
                nxt++;
            end
            if (m_cnt < 0) begin
                if (acc) m_cnt = 0;
            end else if (m_cnt == 15) begin
                if (m_hold) begin
                    m_hold = 1'b0;
                    m_cnt = 0;
                end else if (acc) m_cnt = 0;
                else m_cnt = -1;
            end else begin
                m_cnt++;
                if (acc) m_hold = 1'b1;
            end
        end
        load = 1'b0;
        tests_run++;
        if (frames != 80 || done_count - d0 != 5 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL sustained_totals: frames=%0d dones=%0d left=%0d required 80 5 0",
                     frames, done_count - d0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_overflow();
        test_handoff();
        test_mid_reset();
        test_sustained();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 Parameter: WIDTH, 16, word width in bits; only WIDTH=16 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in  input  16  parallel word offered for transmission.
REQ-005 load  input  1  offer strobe; a word SHALL be accepted on a rising edge where load=1 and ready=1.
REQ-006 ready  output  1  SHALL be 1 exactly when the one-word holding buffer is empty.
REQ-007 sout  output  1  serial data bit, MSB first.
REQ-008 sframe  output  1  SHALL be 1 exactly in the cycles where sout carries a valid data bit.
REQ-009 busy  output  1  SHALL equal sframe OR holding-buffer-valid.
REQ-010 done  output  1  one-cycle pulse marking the last bit of each word.

Function
REQ-011 State SHALL consist of: FSM {IDLE, SHIFT}; 16-bit shift register; 4-bit bit counter; 16-bit holding buffer with valid flag.
REQ-012 sout, sframe and done SHALL be driven from registers (no combinational path from in or load).
REQ-013 IDLE + accepted load at edge N: in SHALL go straight into the shift register, FSM -> SHIFT, counter=0; in[15] SHALL appear on sout in the cycle after edge N (latency 1).
REQ-014 SHIFT: each edge SHALL shift the register left by one and increment the counter; sout SHALL present in[15], in[14], ... in[0] in 16 consecutive cycles with sframe=1.
REQ-015 done SHALL be 1 only in the cycle presenting bit 0 (counter=15), with sframe=1.
REQ-016 Load accepted while SHIFT and not on the last-bit edge: word SHALL go to the holding buffer; ready SHALL drop to 0 in the following cycle.
REQ-017 Last-bit edge (counter=15) with holding buffer valid: held word SHALL move into the shift register, counter=0, FSM stays SHIFT, buffer cleared; no gap cycle (sframe stays 1).
REQ-018 Last-bit edge, buffer empty, load accepted on that same edge: the new word SHALL go directly to the shift register, no gap cycle.
REQ-019 Last-bit edge, buffer empty, no load: FSM -> IDLE; sframe=0, sout=0 in the next cycle.
REQ-020 Last-bit edge with buffer valid AND load=1: ready=1 is impossible here (buffer full); load SHALL be ignored.
REQ-021 load=1 while ready=0 SHALL be ignored: no state change, word dropped.
REQ-022 sout SHALL be 0 whenever sframe=0.
REQ-023 Sustained back-to-back offers SHALL yield continuous sframe=1 with exactly 16 bits per word and one done per word.

Reset
REQ-024 On a rising edge with rst_n=0: FSM=IDLE, shift register=0, counter=0, holding buffer cleared; outputs next cycle: sout=0, sframe=0, done=0, busy=0, ready=1.
REQ-025 Reset mid-word SHALL abort transmission immediately; in-flight and held words SHALL be discarded, with no done pulse.
REQ-026 load SHALL be ignored on any edge where rst_n=0.

Verification
REQ-027 Single word: reset, load in=16'hA5C3 one cycle -> sout = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over 16 cycles, sframe=1 throughout, done only on 16th, then IDLE.
REQ-028 Back-to-back: load 16'hFFFF, then load 16'h0001 at cycle 3 -> ready=0 from cycle 4, 32 contiguous sframe cycles, sixteen 1s then fifteen 0s then 1, two done pulses.
REQ-029 Overflow: with a word shifting and one held, pulse load with 16'h1234 -> ignored; only the first two words appear on sout.
REQ-030 Last-edge handoff: buffer empty, load 16'h8000 on the edge where done=1 -> no sframe gap; next word starts with 1 followed by fifteen 0s.
REQ-031 Mid-word reset: assert rst_n=0 at bit 7 of 16'hF0F0 -> next cycle sframe=0, sout=0, busy=0, ready=1, no done pulse; later load 16'h0F0F transmits correctly.
REQ-032 Idle stability: 20 cycles with no load after reset -> sout=0, sframe=0, done=0, busy=0, ready=1 throughout.
